// File: rtl/edge_threshold_gate.sv
// rtl/edge_threshold_gate.sv - run-time threshold edge flag with frame blanking and edge counting
// Optional hysteresis build: define EDGE_THR_HYST_EN.
module edge_threshold_gate #(
    parameter int DATA_W        = 8,
    parameter int BLANK_SAMPLES = 5,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enb,
    input  logic              sof,
    input  logic [DATA_W-1:0] In1,
    input  logic [DATA_W-1:0] thr_hi,
    input  logic [DATA_W-1:0] thr_lo,
    output logic              u,
    output logic              u_valid,
    output logic              blanking,
    output logic [CNT_W-1:0]  edge_count,
    output logic [CNT_W-1:0]  frame_edges
);

    localparam int BW = (BLANK_SAMPLES < 1) ? 1 : $clog2(BLANK_SAMPLES + 1);
    localparam logic [BW-1:0]    BLANK_LAST = BW'(BLANK_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic {ST_BLANK, ST_RUN} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic [BW-1:0]   bcnt_base, bcnt_inc;
    logic            restart, in_blank, sample_blanked, rise, flag;
    logic [CNT_W-1:0] ec_inc;

`ifdef EDGE_THR_HYST_EN
    logic h_q, h_d, h_base, fall;
`else
    logic unused_thr_lo;
    assign unused_thr_lo = ^thr_lo;
`endif

    always_comb begin
        state_d        = state_q;
        bcnt_d         = bcnt_q;
        restart        = enb & sof;
        in_blank       = restart | (state_q == ST_BLANK);
        // A frame start restarts the count with this sample as blank sample 1.
        bcnt_base      = restart ? '0 : bcnt_q;
        bcnt_inc       = bcnt_base + 1'b1;
        sample_blanked = in_blank && (BLANK_SAMPLES != 0);
        rise           = In1 > thr_hi;
`ifdef EDGE_THR_HYST_EN
        fall   = In1 < thr_lo;
        h_base = restart ? 1'b0 : h_q;
        if (sample_blanked)
            h_d = 1'b0;
        else if (rise)
            h_d = 1'b1;
        else if (fall)
            h_d = 1'b0;
        else
            h_d = h_base;
        flag = h_d;
`else
        flag = !sample_blanked && rise;
`endif
        if (enb) begin
            if (sample_blanked) begin
                bcnt_d  = bcnt_inc;
                state_d = (bcnt_inc >= BLANK_LAST) ? ST_RUN : ST_BLANK;
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    assign ec_inc = (edge_count == CNT_MAX) ? edge_count : edge_count + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BLANK;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // blanking reports whether the most recent valid sample was blanked.
    always_ff @(posedge clk) begin
        if (reset) begin
            u           <= 1'b0;
            u_valid     <= 1'b0;
            blanking    <= 1'b1;
            edge_count  <= '0;
            frame_edges <= '0;
        end else begin
            u       <= enb & flag;
            u_valid <= enb;
            if (enb) begin
                blanking <= sample_blanked;
                if (restart) begin
                    frame_edges <= edge_count;
                    edge_count  <= flag ? CNT_W'(1) : '0;
                end else if (flag) begin
                    edge_count <= ec_inc;
                end
            end
        end
    end

`ifdef EDGE_THR_HYST_EN
    always_ff @(posedge clk) begin
        if (reset)
            h_q <= 1'b0;
        else if (enb)
            h_q <= h_d;
    end
`endif

endmodule

// File: tb/tb_edge_threshold_gate.sv
// tb/tb_edge_threshold_gate.sv - scoreboard bench for edge_threshold_gate
module tb_edge_threshold_gate;

    logic       clk = 1'b0;
    logic       reset, enb, sof;
    logic [7:0] In1, thr_hi, thr_lo;
    logic       u, u_valid, blanking;
    logic [3:0] edge_count, frame_edges;

    always #5 clk = ~clk;

    edge_threshold_gate #(.DATA_W(8), .BLANK_SAMPLES(5), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .enb(enb), .sof(sof), .In1(In1),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .u(u), .u_valid(u_valid),
        .blanking(blanking), .edge_count(edge_count), .frame_edges(frame_edges)
    );

    typedef struct packed {
        logic       u;
        logic       bl;
        logic [3:0] ec;
        logic [3:0] fe;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   stall  = 0;
    bit   mon_en = 1'b0;
    logic hy_u[5];
    int   hy_ec[5];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic send(input logic s, input logic [7:0] d, input logic [7:0] hi, input logic [7:0] lo,
                        input logic eu, input logic eb, input int ec, input int fe);
        @(posedge clk) #1;
        enb = 1'b1; sof = s; In1 = d; thr_hi = hi; thr_lo = lo;
        q.push_back('{u: eu, bl: eb, ec: 4'(ec), fe: 4'(fe)});
    endtask

    // thr_lo = thr_hi + 1 makes hysteresis behave as a plain strict compare.
    task automatic sendn(input logic s, input logic [7:0] d, input logic eu, input logic eb,
                         input int ec, input int fe);
        send(s, d, 8'd20, 8'd21, eu, eb, ec, fe);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk) #1;
            enb = 1'b0; sof = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (u_valid) begin
                    stall = 0;
                    if (q.size() == 0) begin
                        check("unexpected_valid", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("u", int'(u), int'(e.u));
                        check("blanking", int'(blanking), int'(e.bl));
                        check("edge_count", int'(edge_count), int'(e.ec));
                        check("frame_edges", int'(frame_edges), int'(e.fe));
                    end
                end else begin
                    check("gap_u", int'(u), 0);
                    if (q.size() > 0) begin
                        stall++;
                        if (stall > 4) begin
                            check("output_timeout", 1, 0);
                            q.delete();
                            stall = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
`ifdef EDGE_THR_HYST_EN
        hy_u  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        hy_ec = '{2, 3, 4, 4, 4};
`else
        hy_u  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        hy_ec = '{2, 2, 2, 2, 2};
`endif
        reset = 1'b1; enb = 1'b0; sof = 1'b0; In1 = '0; thr_hi = 8'd20; thr_lo = 8'd21;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_u", int'(u), 0);
        check("reset_u_valid", int'(u_valid), 0);
        check("reset_blanking", int'(blanking), 1);
        check("reset_edge_count", int'(edge_count), 0);
        check("reset_frame_edges", int'(frame_edges), 0);
        mon_en = 1'b1;

        for (int i = 0; i < 5; i++) sendn(1'b0, 8'd200, 1'b0, 1'b1, 0, 0);
        sendn(1'b0, 8'd200, 1'b1, 1'b0, 1, 0);

        sendn(1'b0, 8'd20, 1'b0, 1'b0, 1, 0);
        sendn(1'b0, 8'd21, 1'b1, 1'b0, 2, 0);
        sendn(1'b0, 8'd0,  1'b0, 1'b0, 2, 0);
        for (int k = 3; k <= 7; k++) begin
            sendn(1'b0, 8'd200, 1'b1, 1'b0, k, 0);
            if (k % 2 == 1) idle(1);
        end

        sendn(1'b1, 8'd200, 1'b0, 1'b1, 0, 7);
        for (int i = 2; i <= 5; i++) begin
            idle(2);
            sendn(1'b0, 8'd200, 1'b0, 1'b1, 0, 7);
        end
        sendn(1'b0, 8'd200, 1'b1, 1'b0, 1, 7);

        for (int k = 2; k <= 20; k++) sendn(1'b0, 8'd200, 1'b1, 1'b0, (k > 15) ? 15 : k, 7);

        sendn(1'b1, 8'd200, 1'b0, 1'b1, 0, 15);
        sendn(1'b1, 8'd200, 1'b0, 1'b1, 0, 0);
        for (int i = 0; i < 4; i++) sendn(1'b0, 8'd200, 1'b0, 1'b1, 0, 0);
        sendn(1'b0, 8'd200, 1'b1, 1'b0, 1, 0);

        send(1'b0, 8'd40, 8'd30, 8'd10, hy_u[0], 1'b0, hy_ec[0], 0);
        send(1'b0, 8'd20, 8'd30, 8'd10, hy_u[1], 1'b0, hy_ec[1], 0);
        send(1'b0, 8'd15, 8'd30, 8'd10, hy_u[2], 1'b0, hy_ec[2], 0);
        send(1'b0, 8'd9,  8'd30, 8'd10, hy_u[3], 1'b0, hy_ec[3], 0);
        send(1'b0, 8'd20, 8'd30, 8'd10, hy_u[4], 1'b0, hy_ec[4], 0);
        idle(3);

        @(posedge clk) #1;
        reset = 1'b1; enb = 1'b1; sof = 1'b1; In1 = 8'd200; thr_hi = 8'd20; thr_lo = 8'd21;
        @(posedge clk) #1;
        reset = 1'b0; enb = 1'b0; sof = 1'b0;
        @(negedge clk);
        check("midreset_u_valid", int'(u_valid), 0);
        check("midreset_blanking", int'(blanking), 1);
        check("midreset_edge_count", int'(edge_count), 0);
        check("midreset_frame_edges", int'(frame_edges), 0);
        for (int i = 0; i < 5; i++) sendn(1'b0, 8'd200, 1'b0, 1'b1, 0, 0);
        sendn(1'b0, 8'd200, 1'b1, 1'b0, 1, 0);
        idle(4);

        check("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
